// File: rtl/slice_serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b, evaluated as
// a + ~b + 1 one carry-lookahead slice per clock, LSB slice first.
// The inter-slice carry is held in a register. Valid/ready handshakes
// are used on both the operand side and the result side.
module slice_serial_subtractor #(
  parameter int WIDTH = 15,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int BW  = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, nb_q, diff_q;
  logic [IW-1:0]    idx;
  logic             carry_q, borrow_q, ovf_q;
  logic             accept, last;

  logic [BW-1:0]    base;
  logic [SLICE-1:0] sa, sb, p, g, sum;
  logic [SLICE:0]   c;
  logic             term, acc;

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign accept      = start_valid && start_ready;
  assign last        = (idx == LAST);
  assign diff        = diff_q;
  assign borrow_out  = borrow_q;
  assign overflow    = ovf_q;

  // Current slice: operand select and lookahead carries.
  // Each carry is a flat sum-of-products of g/p and carry-in, so nothing
  // ripples through the slice; only the registered carry links slices.
  always_comb begin
    base = BW'(idx) * BW'(SLICE);
    sa   = a_q[base +: SLICE];
    sb   = nb_q[base +: SLICE];
    p    = sa ^ sb;
    g    = sa & sb;
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = carry_q;
    for (int unsigned i = 0; i < SLICE; i++) begin
      term = carry_q;
      for (int unsigned j = 0; j <= i; j++) term = term & p[j];
      acc = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    sum = p ^ c[SLICE-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice result write-back and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      idx      <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      nb_q     <= ~b;
      diff_q   <= '0;
      idx      <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state == RUN) begin
      diff_q[base +: SLICE] <= sum;
      carry_q               <= c[SLICE];
      if (last) begin
        idx      <= '0;
        borrow_q <= ~c[SLICE];
        // b's sign is recovered from the stored complement.
        ovf_q    <= (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[SLICE-1]);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_slice_serial_subtractor.sv
// Bench for slice_serial_subtractor: directed vector table, hand-written
// handshake/reset sequences and random operands against an arithmetic model.
module tb_slice_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [14:0] a = '0;
  logic [14:0] b = '0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [14:0] diff;
  logic        borrow_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slice_serial_subtractor #(.WIDTH(15), .SLICE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b),
    .done_valid(done_valid), .done_ready(done_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic [14:0] d;
    logic        br;
    logic        ov;
    int          hold;
    bit          scramble;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the 15-bit values.
  task automatic model(input logic [14:0] av, input logic [14:0] bv,
                       output logic [14:0] d, output logic br, output logic ov);
    int sa, sb, sd;
    sa = av[14] ? int'(av) - 32768 : int'(av);
    sb = bv[14] ? int'(bv) - 32768 : int'(bv);
    sd = sa - sb;
    ov = (sd < -16384) || (sd > 16383);
    d  = 15'((int'(av) - int'(bv)) & 32'h7FFF);
    br = (av < bv);
  endtask

  // Wait (bounded) for done_valid, counting negedges after the current one.
  task automatic wait_done(output int cyc, input bit scramble);
    cyc = 0;
    while (!done_valid && cyc < 20) begin
      if (scramble) begin
        a = 15'($urandom);
        b = 15'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (!done_valid) chk("start_ready_low_in_run", start_ready, 0);
    end
  endtask

  task automatic do_op(input logic [14:0] av, input logic [14:0] bv,
                       input logic [14:0] ed, input logic eb, input logic eo,
                       input int hold, input bit scramble);
    int cyc;
    done_ready = 1'b0;
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    a = av; b = bv; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("accepted", start_ready, 0);
    chk("diff_cleared_on_accept", diff, 0);
    wait_done(cyc, scramble);
    chk("latency", cyc, 5);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("overflow", overflow, eo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_done_valid", done_valid, 1);
      chk("hold_diff", diff, ed);
      chk("hold_borrow", borrow_out, eb);
      chk("hold_ovf", overflow, eo);
      chk("hold_start_ready", start_ready, 0);
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk("back_idle_done_valid", done_valid, 0);
    chk("back_idle_start_ready", start_ready, 1);
    chk("retained_diff", diff, ed);
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    int seen;
    logic [14:0] md;
    logic mb, mo;
    logic [14:0] ra, rb;

    vecs.push_back('{15'd100,    15'd37,     15'd63,     1'b0, 1'b0, 0,  1'b0});
    vecs.push_back('{15'd5,      15'd9,      15'h7FFC,   1'b1, 1'b0, 1,  1'b0});
    vecs.push_back('{15'h3FFF,   15'h4000,   15'h7FFF,   1'b1, 1'b1, 0,  1'b0});
    vecs.push_back('{15'd0,      15'd0,      15'd0,      1'b0, 1'b0, 10, 1'b0});
    vecs.push_back('{15'h7FFF,   15'd1,      15'h7FFE,   1'b0, 1'b0, 0,  1'b1});
    vecs.push_back('{15'h4000,   15'd1,      15'h3FFF,   1'b0, 1'b1, 0,  1'b0});
    vecs.push_back('{15'd0,      15'd1,      15'h7FFF,   1'b1, 1'b0, 0,  1'b0});
    vecs.push_back('{15'h1249,   15'h1249,   15'd0,      1'b0, 1'b0, 2,  1'b0});

    // Reset values while rst_n is asserted.
    #12;
    chk("rst_done_valid", done_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_start_ready", start_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov,
            vecs[i].hold, vecs[i].scramble);

    // Reset pulsed mid-RUN at slice index 2.
    @(negedge clk);
    a = 15'd1234; b = 15'd77; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_idle", start_ready, 1);
    chk("midrun_rst_diff", diff, 0);
    chk("midrun_rst_done_valid", done_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    do_op(15'd20, 15'd20, 15'd0, 1'b0, 1'b0, 0, 1'b0);

    // done_ready with start_valid in DONE: only DONE->IDLE that edge;
    // done_ready held high outside DONE is ignored.
    @(negedge clk);
    a = 15'd50; b = 15'd60; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    wait_done(cyc, 1'b0);
    chk("seq_latency", cyc, 5);
    model(15'd50, 15'd60, md, mb, mo);
    chk("seq_diff", diff, md);
    a = 15'd300; b = 15'd45;
    done_ready = 1'b1; start_valid = 1'b1;
    @(negedge clk);
    chk("seq_not_accepted_from_done", start_ready, 1);
    chk("seq_done_dropped", done_valid, 0);
    chk("seq_retained", diff, md);
    @(negedge clk);
    start_valid = 1'b0;
    chk("seq_accepted_in_idle", start_ready, 0);
    chk("seq_done_ready_ignored", done_valid, 0);
    wait_done(cyc, 1'b0);
    chk("seq2_latency", cyc, 5);
    model(15'd300, 15'd45, md, mb, mo);
    chk("seq2_diff", diff, md);
    chk("seq2_borrow", borrow_out, mb);
    chk("seq2_ovf", overflow, mo);
    @(negedge clk);
    done_ready = 1'b0;
    chk("seq2_idle", start_ready, 1);

    // Random operands against the model.
    for (int n = 0; n < 40; n++) begin
      ra = 15'($urandom);
      rb = 15'($urandom);
      if (n % 8 == 0) rb = ra;
      model(ra, rb, md, mb, mo);
      do_op(ra, rb, md, mb, mo, int'($urandom_range(0, 2)), n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
